// File: rtl/bird_plotter_if.sv
// Request and pixel-stream bundle between the sprite sequencer and bird_plotter.
// The master side issues move requests; the slave side (bird_plotter) answers
// with the vga_adapter pixel stream and its status.
interface bird_plotter_if;
  logic       req_valid;
  logic       req_ready;
  logic       erase_en;
  logic [7:0] old_x;
  logic [6:0] old_y;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] draw_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, erase_en, old_x, old_y, new_x, new_y, draw_colour,
    input  req_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    input  req_valid, erase_en, old_x, old_y, new_x, new_y, draw_colour,
    output req_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/bird_plotter.sv
// bird_plotter: erases a 13-pixel bird at its old anchor with the background
// colour, then draws it at the new anchor, one pixel per clock, and pulses done.
// Off-screen pixels are suppressed but still take their cycle, so the latency
// of a move is fixed regardless of position.
module bird_plotter #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic          clock,
  input  logic          reset,
  bird_plotter_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Sequencer state and latched request
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] old_x_q, old_x_d;
  logic [6:0] old_y_q, old_y_d;
  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic [2:0] colour_q, colour_d;

  // Registered outputs
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       req_ready_q, req_ready_d;

  // Pixel datapath for the upcoming cycle
  logic              pass_active;
  logic              pass_erase;
  logic [7:0]        anchor_x;
  logic [6:0]        anchor_y;
  logic signed [3:0] dx;
  logic signed [3:0] dy;
  logic [8:0]        px;
  logic [7:0]        py;
  logic              in_view;

  // Horizontal offset of each sprite pixel from its anchor (beak at dx=0).
  function automatic logic signed [3:0] shape_dx(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1:  shape_dx = 4'sd0;
      4'd2:        shape_dx = -4'sd1;
      4'd3:        shape_dx = -4'sd2;
      4'd4:        shape_dx = -4'sd3;
      4'd5:        shape_dx = -4'sd4;
      4'd6:        shape_dx = -4'sd5;
      4'd7, 4'd8:  shape_dx = -4'sd3;
      4'd9, 4'd10: shape_dx = -4'sd4;
      4'd11, 4'd12: shape_dx = -4'sd5;
      default:     shape_dx = 4'sd0;
    endcase
  endfunction

  // Vertical offset of each sprite pixel: body row, then wing pairs above/below.
  function automatic logic signed [3:0] shape_dy(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd7: shape_dy = 4'sd1;
      4'd8:       shape_dy = -4'sd1;
      4'd9:       shape_dy = 4'sd2;
      4'd10:      shape_dy = -4'sd2;
      4'd11:      shape_dy = 4'sd3;
      4'd12:      shape_dy = -4'sd3;
      default:    shape_dy = 4'sd0;
    endcase
  endfunction

  // Next-state logic: accept in IDLE, walk idx through each pass, then DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    old_x_d  = old_x_q;
    old_y_d  = old_y_q;
    new_x_d  = new_x_q;
    new_y_d  = new_y_q;
    colour_d = colour_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          old_x_d  = bus.old_x;
          old_y_d  = bus.old_y;
          new_x_d  = bus.new_x;
          new_y_d  = bus.new_y;
          colour_d = bus.draw_colour;
          idx_d    = 4'd0;
          state_d  = bus.erase_en ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          state_d = S_DRAW;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DRAW: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so that every output is a flop and the
  // pixel for a given state/idx appears in the same cycle as that state.
  always_comb begin
    pass_erase  = (state_d == S_ERASE);
    pass_active = (state_d == S_ERASE) || (state_d == S_DRAW);
    anchor_x    = pass_erase ? old_x_d : new_x_d;
    anchor_y    = pass_erase ? old_y_d : new_y_d;
    dx          = shape_dx(idx_d);
    dy          = shape_dy(idx_d);
    // Anchor is non-negative and offsets are small, so the top bit of each
    // sum acts as the sign; a set sign bit or an oversize value is off-screen.
    px          = {1'b0, anchor_x} + {{5{dx[3]}}, dx};
    py          = {1'b0, anchor_y} + {{4{dy[3]}}, dy};
    in_view     = !px[8] && ({1'b0, px[7:0]} < 9'(SCREEN_W)) &&
                  !py[7] && ({1'b0, py[6:0]} < 8'(SCREEN_H));

    vga_plot_d   = pass_active && in_view;
    vga_x_d      = vga_plot_d ? px[7:0] : 8'd0;
    vga_y_d      = vga_plot_d ? py[6:0] : 7'd0;
    vga_colour_d = !pass_active ? 3'b000 : (pass_erase ? BG_COLOUR : colour_d);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    req_ready_d  = (state_d == S_IDLE);
  end

  // State, request latch and output registers; reset returns to an idle, ready block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      old_x_q      <= 8'd0;
      old_y_q      <= 7'd0;
      new_x_q      <= 8'd0;
      new_y_q      <= 7'd0;
      colour_q     <= 3'b000;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'b000;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      colour_q     <= colour_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.req_ready  = req_ready_q;

endmodule

// File: tb/tb_bird_plotter.sv
// Bench for bird_plotter: reset, directed vector table, reset abort,
// back-to-back requests with noisy inputs, and random requests, all compared
// cycle by cycle against a pixel-list reference model.
module tb_bird_plotter;

  logic clock = 1'b0;
  logic reset;

  bird_plotter_if bus();

  bird_plotter #(
    .SCREEN_W (160),
    .SCREEN_H (120),
    .BG_COLOUR(3'b000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Expected outputs for one cycle after the accept edge
  typedef struct {
    bit plot;
    int x;
    int y;
    int col;
    bit busy;
    bit done;
    bit ready;
  } exp_t;

  // Directed vector: request plus hand-derived summary results
  typedef struct {
    bit er;
    int ox, oy, nx, ny, col;
    int exp_plots, exp_done, fx, fy, lx, ly;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   req_no = 0;
  exp_t exp_q[$];

  int dx_tab[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
  int dy_tab[13] = '{0, 1,  0,  0,  0,  0,  0,  1, -1,  2, -2,  3, -3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: the full list of per-cycle outputs for one request, from the
  // sprite table and the screen bounds, followed by the done and idle cycles.
  task automatic build_model(input bit er, input int ox, input int oy,
                             input int nx, input int ny, input int col);
    exp_t e;
    exp_q.delete();
    for (int p = (er ? 0 : 1); p < 2; p++) begin
      for (int i = 0; i < 13; i++) begin
        int px;
        int py;
        px     = ((p == 0) ? ox : nx) + dx_tab[i];
        py     = ((p == 0) ? oy : ny) + dy_tab[i];
        e.plot = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
        e.x    = e.plot ? px : 0;
        e.y    = e.plot ? py : 0;
        e.col  = (p == 0) ? 0 : col;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.ready = 1'b0;
        exp_q.push_back(e);
      end
    end
    e = '{plot: 1'b0, x: 0, y: 0, col: 0, busy: 1'b1, done: 1'b1, ready: 1'b0};
    exp_q.push_back(e);
    e = '{plot: 1'b0, x: 0, y: 0, col: 0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic check_cycle(input int c, input exp_t e);
    check($sformatf("req%0d_c%0d_plot", req_no, c), bus.vga_plot, e.plot);
    check($sformatf("req%0d_c%0d_x", req_no, c), bus.vga_x, e.x);
    check($sformatf("req%0d_c%0d_y", req_no, c), bus.vga_y, e.y);
    check($sformatf("req%0d_c%0d_busy", req_no, c), bus.busy, e.busy);
    check($sformatf("req%0d_c%0d_done", req_no, c), bus.done, e.done);
    check($sformatf("req%0d_c%0d_ready", req_no, c), bus.req_ready, e.ready);
    if (e.plot)
      check($sformatf("req%0d_c%0d_colour", req_no, c), bus.vga_colour, e.col);
  endtask

  task automatic noise_inputs(input bit hold);
    bus.req_valid   = hold;
    bus.erase_en    = 1'($urandom);
    bus.old_x       = 8'($urandom);
    bus.old_y       = 7'($urandom);
    bus.new_x       = 8'($urandom);
    bus.new_y       = 7'($urandom);
    bus.draw_colour = 3'($urandom);
  endtask

  task automatic drive_req(input bit er, input int ox, input int oy,
                           input int nx, input int ny, input int col);
    bus.req_valid   = 1'b1;
    bus.erase_en    = er;
    bus.old_x       = 8'(ox);
    bus.old_y       = 7'(oy);
    bus.new_x       = 8'(nx);
    bus.new_y       = 7'(ny);
    bus.draw_colour = 3'(col);
  endtask

  // Issue one request and follow it to the idle cycle, comparing every cycle.
  // With hold=1 req_valid stays high with random inputs while busy.
  task automatic run_req(input bit er, input int ox, input int oy, input int nx,
                         input int ny, input int col, input bit hold,
                         output int nplots, output int done_cyc, output int waited,
                         output int fx, output int fy, output int lx, output int ly);
    nplots = 0; done_cyc = -1; waited = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    req_no++;
    build_model(er, ox, oy, nx, ny, col);
    while (bus.req_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    check($sformatf("req%0d_ready_before_accept", req_no), bus.req_ready, 1'b1);
    drive_req(er, ox, oy, nx, ny, col);
    step();
    for (int c = 0; c < exp_q.size(); c++) begin
      check_cycle(c + 1, exp_q[c]);
      if (bus.vga_plot === 1'b1) begin
        nplots++;
        if (fx < 0) begin
          fx = int'(bus.vga_x);
          fy = int'(bus.vga_y);
        end
        lx = int'(bus.vga_x);
        ly = int'(bus.vga_y);
      end
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c + 1;
      if (c != exp_q.size() - 1) begin
        noise_inputs(hold);
        step();
      end
    end
    $display("req %0d: erase=%0d old=(%0d,%0d) new=(%0d,%0d) col=%0d plots=%0d done_cycle=%0d",
             req_no, er, ox, oy, nx, ny, col, nplots, done_cyc);
  endtask

  vec_t vecs[6];

  initial begin
    int np, dc, w, fx, fy, lx, ly;

    vecs[0] = '{er: 1, ox: 20, oy: 10, nx: 21, ny: 10, col: 7,
                exp_plots: 26, exp_done: 27, fx: 20, fy: 10, lx: 16, ly: 7};
    vecs[1] = '{er: 0, ox: 0, oy: 0, nx: 5, ny: 7, col: 2,
                exp_plots: 13, exp_done: 14, fx: 5, fy: 7, lx: 0, ly: 4};
    vecs[2] = '{er: 0, ox: 0, oy: 0, nx: 2, ny: 1, col: 3,
                exp_plots: 4, exp_done: 14, fx: 2, fy: 1, lx: 0, ly: 1};
    vecs[3] = '{er: 0, ox: 0, oy: 0, nx: 159, ny: 118, col: 4,
                exp_plots: 11, exp_done: 14, fx: 159, fy: 118, lx: 154, ly: 115};
    vecs[4] = '{er: 1, ox: 2, oy: 1, nx: 159, ny: 118, col: 5,
                exp_plots: 15, exp_done: 27, fx: 2, fy: 1, lx: 154, ly: 115};
    vecs[5] = '{er: 1, ox: 40, oy: 40, nx: 40, ny: 40, col: 0,
                exp_plots: 26, exp_done: 27, fx: 40, fy: 40, lx: 35, ly: 37};

    // Reset held two cycles with a valid request present: nothing accepted.
    reset = 1'b1;
    drive_req(1'b1, 20, 10, 21, 10, 7);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("reset%0d_plot", i), bus.vga_plot, 1'b0);
      check($sformatf("reset%0d_x", i), bus.vga_x, 0);
      check($sformatf("reset%0d_y", i), bus.vga_y, 0);
      check($sformatf("reset%0d_colour", i), bus.vga_colour, 0);
      check($sformatf("reset%0d_done", i), bus.done, 1'b0);
      check($sformatf("reset%0d_busy", i), bus.busy, 1'b0);
      check($sformatf("reset%0d_ready", i), bus.req_ready, 1'b1);
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    step();
    check("post_reset_idle_busy", bus.busy, 1'b0);

    // Reset in cycle 5 of an erase: back to idle with no done and no plots.
    req_no++;
    build_model(1'b1, 20, 10, 21, 10, 7);
    drive_req(1'b1, 20, 10, 21, 10, 7);
    step();
    for (int c = 1; c <= 5; c++) begin
      check_cycle(c, exp_q[c - 1]);
      if (c < 5) begin
        noise_inputs(1'b0);
        step();
      end
    end
    reset = 1'b1;
    step();
    check("abort_plot", bus.vga_plot, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_ready", bus.req_ready, 1'b1);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("abort_after%0d_done", i), bus.done, 1'b0);
      check($sformatf("abort_after%0d_plot", i), bus.vga_plot, 1'b0);
      check($sformatf("abort_after%0d_busy", i), bus.busy, 1'b0);
    end

    // Directed vector table; the first entry also shows recovery after abort.
    for (int v = 0; v < 6; v++) begin
      run_req(vecs[v].er, vecs[v].ox, vecs[v].oy, vecs[v].nx, vecs[v].ny,
              vecs[v].col, 1'b0, np, dc, w, fx, fy, lx, ly);
      check($sformatf("vec%0d_plots", v), np, vecs[v].exp_plots);
      check($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
      check($sformatf("vec%0d_first_x", v), fx, vecs[v].fx);
      check($sformatf("vec%0d_first_y", v), fy, vecs[v].fy);
      check($sformatf("vec%0d_last_x", v), lx, vecs[v].lx);
      check($sformatf("vec%0d_last_y", v), ly, vecs[v].ly);
    end

    // req_valid held high with changing inputs while busy; the next request
    // must be taken on the very edge after req_ready rises.
    run_req(1'b1, 20, 10, 21, 10, 7, 1'b1, np, dc, w, fx, fy, lx, ly);
    check("hold_first_done_cycle", dc, 27);
    check("hold_first_plots", np, 26);
    run_req(1'b0, 0, 0, 5, 7, 2, 1'b0, np, dc, w, fx, fy, lx, ly);
    check("hold_second_wait", w, 0);
    check("hold_second_first_x", fx, 5);
    check("hold_second_done_cycle", dc, 14);

    // Random requests over the full input range, including off-screen anchors.
    for (int r = 0; r < 24; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      bus.req_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
      run_req(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
              1'($urandom), np, dc, w, fx, fy, lx, ly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
